// File: rtl/nibble_serial_adder.sv
// Nibble-serial wide adder: one fulladder4 is reused across N_NIBBLES slices,
// LSB first, with the inter-slice carry held in a register.

module fulladder4 (
   input  logic [3:0] Ain,
   input  logic [3:0] Bin,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout
);

   logic [4:0] total;

   always_comb begin
      total = {1'b0, Ain} + {1'b0, Bin} + {4'd0, Cin};
      Sum   = total[3:0];
      Cout  = total[4];
   end

endmodule

// Handshakes: a transfer occurs on a rising edge where valid && ready are both 1;
// valid, once raised, is held with stable data until that transfer edge.
module nibble_serial_adder #(
   parameter int N_NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*N_NIBBLES-1:0] a_in,
   input  logic [4*N_NIBBLES-1:0] b_in,
   input  logic                   c_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*N_NIBBLES-1:0] sum_out,
   output logic                   c_out,
   output logic [1:0]             dbg_state
);

   localparam int W  = 4 * N_NIBBLES;
   localparam int CW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          c_out_q, c_out_d;
   logic          out_valid_q, out_valid_d;

   logic [W-1:0]  a_shift;
   logic [W-1:0]  b_shift;
   logic [3:0]    fa_sum;
   logic          fa_cout;

   // Slice select: shift the latched operands down by 4*cnt bits.
   always_comb begin
      a_shift = a_q >> {cnt_q, 2'b00};
      b_shift = b_q >> {cnt_q, 2'b00};
   end

   fulladder4 u_fa (
      .Ain  (a_shift[3:0]),
      .Bin  (b_shift[3:0]),
      .Cin  (carry_q),
      .Sum  (fa_sum),
      .Cout (fa_cout)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      c_out_d     = c_out_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               carry_d = c_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < N_NIBBLES; i++) begin
               if (cnt_q == CW'(i)) begin
                  sum_d[4*i +: 4] = fa_sum;
               end
            end
            carry_d = fa_cout;
            if (cnt_q == LAST) begin
               c_out_d     = fa_cout;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         c_out_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         c_out_q     <= c_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // in_ready depends on state and rst only, never on in_valid or out_ready.
   always_comb begin
      in_ready  = (state_q == IDLE) && !rst;
      out_valid = out_valid_q;
      sum_out   = sum_q;
      c_out     = c_out_q;
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (N_NIBBLES=4): reset, carry ripple,
// backpressure, ignored input, mid-run reset and a random back-to-back stream.

module tb_nibble_serial_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        c_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum_out;
   logic        c_out;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   logic [16:0] exp_q[$];

   nibble_serial_adder #(.N_NIBBLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum_out   (sum_out),
      .c_out     (c_out),
      .dbg_state (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Single operation with out_ready high; checks latency, result and pop.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] exp_s, input logic exp_c, input string tag);
      int lat;
      a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_sum"}, sum_out, exp_s);
      chk({tag, "_cout"}, c_out, exp_c);
      step();
      chk({tag, "_pop_valid"}, out_valid, 0);
      chk({tag, "_pop_ready"}, in_ready, 1);
   endtask

   initial begin
      int lat;
      int seen;
      int accepts;
      int results;
      int cycle;
      int last_acc;
      logic accepting;
      logic [16:0] exp;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a_in = '0; b_in = '0; c_in = 1'b0;
      step();
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum_out, 0);
      chk("rst_cout", c_out, 0);
      chk("rst_state", dbg_state, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      do_op(16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, "basic");
      do_op(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, "ripple3");
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "wrap");
      do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "allones");

      // Backpressure
      out_ready = 1'b0;
      a_in = 16'h1234; b_in = 16'h4321; c_in = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk("bp_latency", lat, 4);
      chk("bp_sum", sum_out, 16'h5555);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_sum", sum_out, 16'h5555);
         chk("bp_hold_cout", c_out, 0);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      step();
      chk("bp_pop_valid", out_valid, 0);
      chk("bp_pop_in_ready", in_ready, 1);

      // Ignored input during RUN
      a_in = 16'h1111; b_in = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
      step();
      a_in = 16'hAAAA; b_in = 16'h5555; c_in = 1'b1;
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      in_valid = 1'b0;
      chk("ign_latency", lat, 4);
      chk("ign_sum", sum_out, 16'h3333);
      chk("ign_cout", c_out, 0);
      step();
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (out_valid) seen++;
      end
      chk("ign_no_second", seen, 0);

      // Reset mid-RUN at cnt=2
      a_in = 16'h1234; b_in = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("mid_state_run", dbg_state, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_sum", sum_out, 0);
      chk("mid_rst_cout", c_out, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      do_op(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, "after_rst");

      // Back-to-back random stream, in_valid and out_ready tied high
      accepts = 0; results = 0; cycle = 0; last_acc = -1;
      a_in = 16'($urandom); b_in = 16'($urandom); c_in = 1'($urandom_range(0, 1));
      in_valid = 1'b1; out_ready = 1'b1;
      while (accepts < 1000 && cycle < 20000) begin
         accepting = in_ready;
         if (accepting) begin
            exp = {1'b0, a_in} + {1'b0, b_in} + {16'd0, c_in};
            exp_q.push_back(exp);
            if (last_acc >= 0) chk("b2b_spacing", cycle - last_acc, 6);
            last_acc = cycle;
            accepts++;
         end
         step();
         cycle++;
         if (accepts == 1000) in_valid = 1'b0;
         if (accepting) begin
            a_in = 16'($urandom); b_in = 16'($urandom); c_in = 1'($urandom_range(0, 1));
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("b2b_unexpected_result", 1, 0);
            end else begin
               exp = exp_q.pop_front();
               chk("b2b_result", {c_out, sum_out}, exp);
               results++;
            end
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("b2b_unexpected_result", 1, 0);
            end else begin
               exp = exp_q.pop_front();
               chk("b2b_result", {c_out, sum_out}, exp);
               results++;
            end
         end
      end
      chk("b2b_accepts", accepts, 1000);
      chk("b2b_results", results, 1000);
      chk("b2b_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
